// File: rtl/lfsr_prng_if.sv
// Output word stream of lfsr_prng: valid/ready with back-pressure.
// master drives data/valid, slave drives ready.
interface lfsr_prng_if #(
    parameter int P_OUT_BITS = 1
);
    logic [P_OUT_BITS-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/lfsr_prng.sv
// lfsr_prng: parametrised Fibonacci LFSR whose feedback bits are packed
// MSB-first into P_OUT_BITS-wide words on a valid/ready stream.
// Runtime seed load; zero seeds are rejected with a one-cycle seed_err.
// Optional period monitor enabled by defining LFSR_PERIOD_CNT_EN; without it
// period_cnt/period_wrap are tied to zero.
module lfsr_prng #(
    parameter int                   P_WIDTH     = 32,
    parameter logic [P_WIDTH-1:0]   P_TAPS      = P_WIDTH'(32'h80000062),
    parameter logic [P_WIDTH-1:0]   P_INIT_SEED = '1,
    parameter int                   P_OUT_BITS  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [P_WIDTH-1:0] seed,
    input  logic               seed_wr,
    lfsr_prng_if.master        m_out,
    output logic               seed_err,
    output logic               y,
    output logic [P_WIDTH-1:0] lfsr,
    output logic [P_WIDTH-1:0] period_cnt,
    output logic               period_wrap
);

    if (P_WIDTH < 3 || P_WIDTH > 64) begin : g_bad_width
        $error("lfsr_prng: P_WIDTH must be in 3..64");
    end
    if (P_INIT_SEED == '0) begin : g_bad_seed
        $error("lfsr_prng: P_INIT_SEED must be nonzero");
    end
    if (P_OUT_BITS < 1 || P_OUT_BITS > P_WIDTH) begin : g_bad_out_bits
        $error("lfsr_prng: P_OUT_BITS must be in 1..P_WIDTH");
    end

    logic [P_WIDTH-1:0]    r_sr;
    logic [P_WIDTH-1:0]    w_next;
    logic                  w_y;
    logic                  w_advance;
    logic                  w_seed_ok;
    logic                  w_seed_zero;
    logic                  w_last;
    logic                  w_complete;
    logic [P_OUT_BITS-1:0] w_word;
    logic [P_OUT_BITS-1:0] r_data;
    logic                  r_valid;
    logic                  r_seed_err;

    assign w_y         = ^(r_sr & P_TAPS);
    assign w_next      = {r_sr[P_WIDTH-2:0], w_y};
    assign w_advance   = en && !(r_valid && !m_out.out_ready);
    assign w_seed_ok   = seed_wr && (seed != '0);
    assign w_seed_zero = seed_wr && (seed == '0);
    assign w_complete  = w_advance && w_last;

    // Single-bit words need neither a collector nor a bit counter.
    if (P_OUT_BITS == 1) begin : g_single
        assign w_word = w_y;
        assign w_last = 1'b1;
    end else begin : g_multi
        localparam int CW = $clog2(P_OUT_BITS);
        logic [P_OUT_BITS-2:0] r_col;
        logic [CW-1:0]         r_cnt;

        assign w_word = {r_col, w_y};
        assign w_last = (r_cnt == CW'(P_OUT_BITS - 1));

        // Collector and bit counter: cleared on seed load and on word completion.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_col <= '0;
                r_cnt <= '0;
            end else if (w_seed_ok) begin
                r_col <= '0;
                r_cnt <= '0;
            end else if (w_advance) begin
                if (w_last) begin
                    r_col <= '0;
                    r_cnt <= '0;
                end else begin
                    r_col <= w_word[P_OUT_BITS-2:0];
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    // Shift register: seed load wins over a shift in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= P_INIT_SEED;
        end else if (w_seed_ok) begin
            r_sr <= seed;
        end else if (w_advance) begin
            r_sr <= w_next;
        end
    end

    // Output word register; a completing word replaces one being accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_seed_ok) begin
            r_valid <= 1'b0;
        end else if (w_complete) begin
            r_data  <= w_word;
            r_valid <= 1'b1;
        end else if (r_valid && m_out.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Zero-seed rejection flag, one pulse per rejected strobe cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seed_err <= 1'b0;
        end else begin
            r_seed_err <= w_seed_zero;
        end
    end

`ifdef LFSR_PERIOD_CNT_EN
    logic [P_WIDTH-1:0] r_ref;
    logic [P_WIDTH-1:0] r_pcnt;
    logic               r_wrap;

    // Period monitor: counts shifts and flags return to the start state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref  <= P_INIT_SEED;
            r_pcnt <= '0;
            r_wrap <= 1'b0;
        end else if (w_seed_ok) begin
            r_ref  <= seed;
            r_pcnt <= '0;
            r_wrap <= 1'b0;
        end else if (w_advance) begin
            if (w_next == r_ref) begin
                r_pcnt <= '0;
                r_wrap <= 1'b1;
            end else begin
                r_pcnt <= r_pcnt + P_WIDTH'(1);
                r_wrap <= 1'b0;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign period_cnt  = r_pcnt;
    assign period_wrap = r_wrap;
`else
    assign period_cnt  = '0;
    assign period_wrap = 1'b0;
`endif

    assign m_out.out_data  = r_data;
    assign m_out.out_valid = r_valid;
    assign seed_err        = r_seed_err;
    assign y               = w_y;
    assign lfsr            = r_sr;

endmodule

// File: tb/tb_lfsr_prng.sv
// Directed testbench for lfsr_prng: three instances (32-bit x1-bit words,
// 32-bit x8-bit words, 4-bit x1-bit words) exercised in turn.
// Period-monitor checks follow LFSR_PERIOD_CNT_EN when it is defined.
module tb_lfsr_prng;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Instance d1: defaults, one bit per word
    logic        en1, wr1, err1, y1, pw1;
    logic [31:0] seed1, sr1, pc1;
    lfsr_prng_if #(.P_OUT_BITS(1)) if1 ();

    lfsr_prng u_d1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .seed(seed1), .seed_wr(wr1),
        .m_out(if1), .seed_err(err1), .y(y1), .lfsr(sr1),
        .period_cnt(pc1), .period_wrap(pw1)
    );

    // Instance d8: eight bits per word
    logic        en8, wr8, err8, y8, pw8;
    logic [31:0] seed8, sr8, pc8;
    lfsr_prng_if #(.P_OUT_BITS(8)) if8 ();

    lfsr_prng #(.P_OUT_BITS(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .en(en8), .seed(seed8), .seed_wr(wr8),
        .m_out(if8), .seed_err(err8), .y(y8), .lfsr(sr8),
        .period_cnt(pc8), .period_wrap(pw8)
    );

    // Instance d4: 4-bit LFSR, taps x^4 + x + 1 style, period 15
    logic       en4, wr4, err4, y4, pw4;
    logic [3:0] seed4, sr4, pc4;
    lfsr_prng_if #(.P_OUT_BITS(1)) if4 ();

    lfsr_prng #(
        .P_WIDTH(4), .P_TAPS(4'b1001), .P_INIT_SEED(4'hF), .P_OUT_BITS(1)
    ) u_d4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .seed(seed4), .seed_wr(wr4),
        .m_out(if4), .seed_err(err4), .y(y4), .lfsr(sr4),
        .period_cnt(pc4), .period_wrap(pw4)
    );

    // Hand-derived sequences from the default taps (31,6,5,1) and all-ones seed
    logic [31:0] exp_sr1  [8] = '{32'hFFFFFFFE, 32'hFFFFFFFC, 32'hFFFFFFF9, 32'hFFFFFFF3,
                                  32'hFFFFFFE6, 32'hFFFFFFCC, 32'hFFFFFF98, 32'hFFFFFF31};
    logic        exp_bit1 [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0]  exp_sr4  [15] = '{4'hE, 4'hD, 4'hA, 4'h5, 4'hB, 4'h6, 4'hC, 4'h9,
                                   4'h2, 4'h4, 4'h8, 4'h1, 4'h3, 4'h7, 4'hF};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en1 = 0; wr1 = 0; seed1 = '0; if1.out_ready = 1'b0;
        en8 = 0; wr8 = 0; seed8 = '0; if8.out_ready = 1'b0;
        en4 = 0; wr4 = 0; seed4 = '0; if4.out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_sr1",    64'(sr1), 64'hFFFFFFFF);
        check("rst_valid1", 64'(if1.out_valid), 64'h0);
        check("rst_data1",  64'(if1.out_data), 64'h0);
        check("rst_err1",   64'(err1), 64'h0);
        check("rst_y1",     64'(y1), 64'h0);
        check("rst_pc1",    64'(pc1), 64'h0);
        check("rst_sr4",    64'(sr4), 64'hF);
        rst_n = 1'b1;
        tick();

        // d1: bit stream with out_ready held high
        en1 = 1'b1;
        if1.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("stream_sr[%0d]", i),    64'(sr1), 64'(exp_sr1[i]));
            check($sformatf("stream_bit[%0d]", i),   64'(if1.out_data), 64'(exp_bit1[i]));
            check($sformatf("stream_valid[%0d]", i), 64'(if1.out_valid), 64'h1);
        end

        // d1: zero seed rejected, generation continues
        seed1 = '0;
        wr1   = 1'b1;
        tick();
        wr1 = 1'b0;
        check("zseed_err", 64'(err1), 64'h1);
        check("zseed_sr",  64'(sr1), 64'hFFFFFE62);
        tick();
        check("zseed_err_clr", 64'(err1), 64'h0);
        check("zseed_sr2",     64'(sr1), 64'hFFFFFCC4);

        // d1: stall, then load seed 1 over the pending word
        if1.out_ready = 1'b0;
        tick();
        check("stall_sr1",    64'(sr1), 64'hFFFFFCC4);
        check("stall_valid1", 64'(if1.out_valid), 64'h1);
        seed1 = 32'h00000001;
        wr1   = 1'b1;
        tick();
        wr1 = 1'b0;
        check("load_sr",    64'(sr1), 64'h1);
        check("load_valid", 64'(if1.out_valid), 64'h0);
        check("load_y",     64'(y1), 64'h0);
        tick();
        check("post_load_sr",    64'(sr1), 64'h2);
        check("post_load_y",     64'(y1), 64'h1);
        check("post_load_valid", 64'(if1.out_valid), 64'h1);
        check("post_load_data",  64'(if1.out_data), 64'h0);
        tick();
        check("post_load_hold", 64'(sr1), 64'h2);

        // d1: en=0 freezes shifting but the pending word is still accepted
        en1 = 1'b0;
        if1.out_ready = 1'b1;
        tick();
        check("frz_valid", 64'(if1.out_valid), 64'h0);
        check("frz_sr",    64'(sr1), 64'h2);

        // d8: first word latency and gap-free cadence
        en8 = 1'b1;
        if8.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("w8_early_valid", 64'(if8.out_valid), 64'h0);
        tick();
        check("w8_first_valid", 64'(if8.out_valid), 64'h1);
        check("w8_first_data",  64'(if8.out_data), 64'h31);
        check("w8_first_sr",    64'(sr8), 64'hFFFFFF31);
        tick();
        check("w8_taken_valid", 64'(if8.out_valid), 64'h0);
        for (int i = 0; i < 6; i++) tick();
        check("w8_gap_valid", 64'(if8.out_valid), 64'h0);
        tick();
        check("w8_second_valid", 64'(if8.out_valid), 64'h1);
        check("w8_second_data",  64'(if8.out_data), 64'h1E);
        check("w8_second_sr",    64'(sr8), 64'hFFFF311E);

        // d8: back-pressure holds word and state
        if8.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("bp_valid[%0d]", i), 64'(if8.out_valid), 64'h1);
            check($sformatf("bp_data[%0d]", i),  64'(if8.out_data), 64'h1E);
            check($sformatf("bp_sr[%0d]", i),    64'(sr8), 64'hFFFF311E);
        end
        if8.out_ready = 1'b1;
        tick();
        check("bp_release_valid", 64'(if8.out_valid), 64'h0);
        check("bp_release_sr",    64'(sr8), 64'hFFFE623C);

        // d8: asynchronous reset mid-word (bit counter at 3)
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_sr8",    64'(sr8), 64'hFFFFFFFF);
        check("arst_valid8", 64'(if8.out_valid), 64'h0);
        check("arst_data8",  64'(if8.out_data), 64'h0);
        en8 = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();

        // d4: full period of the 4-bit LFSR and period monitor
        en4 = 1'b1;
        if4.out_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("p4_sr[%0d]", k), 64'(sr4), 64'(exp_sr4[(k - 1) % 15]));
`ifdef LFSR_PERIOD_CNT_EN
            check($sformatf("p4_cnt[%0d]", k),  64'(pc4), 64'(k % 15));
            check($sformatf("p4_wrap[%0d]", k), 64'(pw4), 64'(k == 15));
`else
            if (k == 15) begin
                check("p4_cnt_tied",  64'(pc4), 64'h0);
                check("p4_wrap_tied", 64'(pw4), 64'h0);
            end
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
